// File: rtl/fir_serial_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fir_serial_sched
//  Purpose  : Sample scheduler for the serial FIR core. Issues accepted input
//             samples to the core no faster than one per SLOT clocks, and
//             buffers core results in a DEPTH-entry first-word-fall-through
//             FIFO. A sample is only issued against a free FIFO credit.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_serial_sched #(
    parameter int DIN_BITS  = 16,
    parameter int DOUT_BITS = 36,
    parameter int SLOT      = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [DIN_BITS-1:0]  in_data,
    output logic                 in_ready,
    output logic                 core_load,
    output logic [DIN_BITS-1:0]  core_din,
    input  logic                 core_valid,
    input  logic [DOUT_BITS-1:0] core_dout,
    output logic                 out_valid,
    output logic [DOUT_BITS-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overflow
);

    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_SLOT_W = $clog2(SLOT);
    localparam int c_PTR_W  = $clog2(DEPTH);

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SLOT - 1);
    localparam logic [c_CNT_W:0]    c_DEPTH_X   = (c_CNT_W + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(DEPTH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_SLOT_W-1:0]  r_slot_cnt;
    logic [c_CNT_W-1:0]   r_inflight;
    logic [c_CNT_W-1:0]   r_drop_cnt;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [DOUT_BITS-1:0] r_mem [DEPTH];
    logic                 r_core_load;
    logic [DIN_BITS-1:0]  r_core_din;
    logic                 r_overflow;

    logic                 w_slot_end;
    logic                 w_credit_ok;
    logic                 w_accept;
    logic                 w_core_ret;
    logic                 w_discard;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_write;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: enter RUN on every issue, fall back to IDLE when a slot
    // expires with nothing to reload, abort to IDLE on flush
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_IDLE;
        end else if (w_accept) begin
            w_state_nxt = c_RUN;
        end else if ((r_state == c_RUN) && w_slot_end) begin
            w_state_nxt = c_IDLE;
        end
    end

    // Handshake and FIFO control decodes
    always_comb begin
        w_slot_end  = (r_slot_cnt == c_SLOT_LAST);
        // One credit per FIFO entry, counting results still inside the core
        w_credit_ok = (({1'b0, r_inflight} + {1'b0, r_count}) < c_DEPTH_X);
        in_ready    = !reset && !flush && (r_drop_cnt == '0) && w_credit_ok &&
                      ((r_state == c_IDLE) || ((r_state == c_RUN) && w_slot_end));
        w_accept    = in_valid && in_ready;
        // Guarded so a stray result with nothing in flight cannot underflow
        w_core_ret  = core_valid && (r_inflight != '0);
        w_discard   = core_valid && (flush || (r_drop_cnt != '0));
        w_push      = core_valid && !w_discard;
        w_full      = (r_count == c_DEPTH);
        w_pop       = out_valid && out_ready;
        // A push into a full FIFO only lands when the head leaves the same cycle
        w_write     = w_push && (!w_full || w_pop);
    end

    // Slot timer: counts clocks since the last issue, parked at zero in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt <= '0;
        end else if (flush || w_accept) begin
            r_slot_cnt <= '0;
        end else if ((r_state == c_RUN) && !w_slot_end) begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end else begin
            r_slot_cnt <= '0;
        end
    end

    // Registered issue strobe and sample towards the core
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_load <= 1'b0;
            r_core_din  <= '0;
        end else begin
            r_core_load <= w_accept;
            if (w_accept) begin
                r_core_din <= in_data;
            end
        end
    end

    // In-flight tracking and discard count for results orphaned by a flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            case ({w_accept, w_core_ret})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (flush) begin
                r_drop_cnt <= w_core_ret ? (r_inflight - 1'b1) : r_inflight;
            end else if ((r_drop_cnt != '0) && core_valid) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= core_dout;
        end
    end

    // Sticky overflow: a result arrived with nowhere to go
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign core_load = r_core_load;
    assign core_din  = r_core_din;
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign busy      = (r_state != c_IDLE) || (r_inflight != '0) || (r_count != '0);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_serial_sched
//  Purpose  : Directed self-checking bench for fir_serial_sched with a model
//             core (latency 12, result = sample * 3) and a manual result stub.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_serial_sched;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        core_load;
    logic [15:0] core_din;
    logic        core_valid;
    logic [35:0] core_dout;
    logic        out_valid;
    logic [35:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        overflow;

    logic        model_en;
    logic        man_valid;
    logic [35:0] man_dout;
    logic        pv [12];
    logic [35:0] pd [12];

    int          n_checks;
    int          n_fail;
    int          n_send;
    int          sent;
    int          loads;
    logic        last_acc;
    logic [35:0] got [$];

    fir_serial_sched #(
        .DIN_BITS  (16),
        .DOUT_BITS (36),
        .SLOT      (8),
        .DEPTH     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .core_load  (core_load),
        .core_din   (core_din),
        .core_valid (core_valid),
        .core_dout  (core_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model core: fixed 12-clock latency, result = 3 * sample
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 12; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= core_load;
            pd[0] <= 36'(core_din) * 36'd3;
            for (int i = 1; i < 12; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign core_valid = (model_en && pv[11]) || man_valid;
    assign core_dout  = man_valid ? man_dout : pd[11];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock, recording handshakes seen in the cycle just ending
    task automatic step();
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) got.push_back(out_data);
        if (core_load) loads++;
        @(posedge clk);
        #1;
    endtask

    // Stream driver: hold in_valid while samples remain, data = index + 1
    task automatic feed();
        if (last_acc) sent++;
        in_valid = (sent < n_send);
        in_data  = 16'(sent + 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_load",  64'(core_load), 64'd0);
        check("rst_din",   64'(core_din),  64'd0);
        check("rst_ovalid",64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_ovf",   64'(overflow),  64'd0);
        check("rst_rdy",   64'(in_ready),  64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        sent  = 0;
        loads = 0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_en  = 1'b1;
        man_valid = 1'b0;
        man_dout  = '0;
        last_acc  = 1'b0;
        n_send    = 0;

        // T1: back-to-back issue spacing
        do_reset();
        out_ready = 1'b1;
        n_send = 4; in_valid = 1'b1; in_data = 16'd1;
        for (int c = 0; c < 28; c++) begin
            check($sformatf("t1_rdy_c%0d", c), 64'(in_ready),
                  64'((c == 0) || (c == 8) || (c == 16) || (c == 24)));
            check($sformatf("t1_load_c%0d", c), 64'(core_load),
                  64'((c == 1) || (c == 9) || (c == 17) || (c == 25)));
            if (c == 25) check("t1_din4", 64'(core_din), 64'd4);
            step(); feed();
        end
        for (int c = 0; c < 20; c++) begin step(); feed(); end
        check("t1_nres", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("t1_res%0d", i), 64'(got[i]), 64'(3 * (i + 1)));

        // T2: credit limit under backpressure, then drain
        do_reset();
        out_ready = 1'b0;
        n_send = 6; in_valid = 1'b1; in_data = 16'd1;
        for (int c = 0; c < 45; c++) begin step(); feed(); end
        check("t2_loads", 64'(loads), 64'd4);
        check("t2_rdy",   64'(in_ready), 64'd0);
        check("t2_oval",  64'(out_valid), 64'd1);
        check("t2_head",  64'(out_data), 64'd3);
        check("t2_busy",  64'(busy), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin step(); feed(); end
        check("t2_loads6", 64'(loads), 64'd6);
        check("t2_nres", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("t2_res%0d", i), 64'(got[i]), 64'(3 * (i + 1)));
        check("t2_ovf", 64'(overflow), 64'd0);

        // T3: idle gap between samples
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 36; c++) begin
            in_valid = (c == 0) || (c == 20);
            in_data  = (c < 20) ? 16'd5 : 16'd7;
            if (c <= 21)
                check($sformatf("t3_rdy_c%0d", c), 64'(in_ready),
                      64'((c == 0) || ((c >= 8) && (c <= 20))));
            check($sformatf("t3_load_c%0d", c), 64'(core_load), 64'((c == 1) || (c == 21)));
            if (c == 12) check("t3_busy", 64'(busy), 64'd1);
            if (c == 21) check("t3_din", 64'(core_din), 64'd7);
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check("t3_nres", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            check("t3_res0", 64'(got[0]), 64'd15);
            check("t3_res1", 64'(got[1]), 64'd21);
        end

        // T4: flush with two results in flight and one buffered
        do_reset();
        out_ready = 1'b0;
        n_send = 3; in_valid = 1'b1; in_data = 16'd1;
        for (int c = 0; c <= 30; c++) begin
            flush = (c == 18);
            if (c == 30) begin
                n_send = 4; in_valid = 1'b1; in_data = 16'd4; out_ready = 1'b1;
            end
            #1;
            if (c == 17) check("t4_pre_oval", 64'(out_valid), 64'd1);
            if (c == 18) check("t4_rdy_flush", 64'(in_ready), 64'd0);
            if (c == 19) begin
                check("t4_oval0", 64'(out_valid), 64'd0);
                check("t4_busy",  64'(busy), 64'd1);
            end
            if (c == 22) begin
                check("t4_drop1_oval", 64'(out_valid), 64'd0);
                check("t4_drop1_rdy",  64'(in_ready), 64'd0);
            end
            if (c == 29) check("t4_rdy29", 64'(in_ready), 64'd0);
            if (c == 30) check("t4_rdy30", 64'(in_ready), 64'd1);
            step(); feed();
        end
        flush = 1'b0;
        for (int c = 0; c < 25; c++) begin step(); feed(); end
        check("t4_nres", 64'(got.size()), 64'd1);
        if (got.size() == 1) check("t4_res", 64'(got[0]), 64'd12);

        // T5: stub forces a result into a full FIFO
        do_reset();
        out_ready = 1'b0;
        man_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            man_dout = 36'(100 + i);
            step();
        end
        man_dout = 36'd200;
        check("t5_ovf_pre", 64'(overflow), 64'd0);
        step();
        man_valid = 1'b0;
        #1;
        check("t5_ovf", 64'(overflow), 64'd1);
        check("t5_head", 64'(out_data), 64'd100);
        for (int c = 0; c < 3; c++) step();
        check("t5_ovf_hold", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("t5_nres", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("t5_res%0d", i), 64'(got[i]), 64'(100 + i));
        check("t5_ovf_end", 64'(overflow), 64'd1);

        // T6: reset while running with three results outstanding
        out_ready = 1'b0;
        model_en  = 1'b0;
        got.delete();
        sent = 0; n_send = 3; in_valid = 1'b1; in_data = 16'd1;
        for (int c = 0; c < 17; c++) begin
            man_valid = (c == 2);
            man_dout  = 36'd55;
            step(); feed();
        end
        man_valid = 1'b0;
        #1;
        check("t6_pre_load", 64'(core_load), 64'd1);
        check("t6_pre_oval", 64'(out_valid), 64'd1);
        check("t6_pre_busy", 64'(busy), 64'd1);
        check("t6_pre_ovf",  64'(overflow), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_load", 64'(core_load), 64'd0);
        check("t6_oval", 64'(out_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ovf",  64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t6_rdy", 64'(in_ready), 64'd1);
        check("t6_busy_rel", 64'(busy), 64'd0);
        man_valid = 1'b1;
        man_dout  = 36'd77;
        step();
        man_valid = 1'b0;
        #1;
        check("t6_late_oval", 64'(out_valid), 64'd1);
        check("t6_late_data", 64'(out_data), 64'd77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
